// File: rtl/fft_bin_reorder.sv
// Converts bit-reversed complex FFT bins into natural-order power values (re^2+im^2 >> SHIFT)
// through a two-bank ping-pong buffer, with valid/ready handshakes on both sides.
module fft_bin_reorder #(
  parameter int unsigned N_LOG2    = 8,
  parameter int unsigned SHIFT     = 1,
  parameter bit          BITREV_IN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_data,
  input  logic        i_data_valid,
  input  logic        i_data_last,
  output logic        o_data_ready,
  output logic [31:0] o_data,
  output logic        o_data_valid,
  output logic        o_data_last,
  input  logic        i_data_ready,
  output logic        o_frame_err
);

  localparam int unsigned AW    = N_LOG2;
  localparam int unsigned DW    = 32;
  localparam int unsigned PW    = 33;
  localparam int unsigned DEPTH = 2 << N_LOG2;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_e;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

  // write side
  logic          ready_q, ready_d;
  logic [AW-1:0] wr_cnt_q;
  logic          wr_bank_q, wr_bank_d;
  logic          wr_acc_c, wr_end_c;
  logic          err_q;

  // power pipeline
  logic signed [15:0] re_c, im_c;
  logic signed [31:0] pre_c, pim_c;
  logic               s1_vld_q, s1_end_q, s1_bank_q;
  logic [AW-1:0]      s1_addr_q;
  logic [31:0]        s1_pre_q, s1_pim_q;
  logic [PW-1:0]      psum_c;
  logic [DW-1:0]      pwr_c;

  logic [DW-1:0] mem [DEPTH];

  bank_e bank_q [2];
  bank_e bank_d [2];

  // read side
  logic          rd_bank_q;
  logic [AW-1:0] rd_addr_q;
  logic          rd_avail_c, rd_issue_c, rd_end_c;
  logic [1:0]    occ_c;
  logic          ram_vld_q, ram_last_q;
  logic [DW-1:0] ram_data_q;
  logic          skid_vld_q, skid_last_q;
  logic [DW-1:0] skid_data_q;
  logic          out_vld_q, out_last_q;
  logic [DW-1:0] out_data_q;
  logic          drain_bank_q;
  logic          pop_c;

  assign wr_acc_c  = i_data_valid && ready_q;
  assign wr_end_c  = (wr_cnt_q == '1);
  assign wr_bank_d = wr_bank_q ^ (wr_acc_c && wr_end_c);

  assign re_c   = i_data[15:0];
  assign im_c   = i_data[31:16];
  assign pre_c  = 32'(re_c) * 32'(re_c);
  assign pim_c  = 32'(im_c) * 32'(im_c);
  assign psum_c = PW'(s1_pre_q) + PW'(s1_pim_q);
  assign pwr_c  = DW'(psum_c >> SHIFT);

  assign pop_c      = out_vld_q && i_data_ready;
  assign rd_avail_c = (bank_q[rd_bank_q] == B_FULL) || (bank_q[rd_bank_q] == B_DRAINING);
  // Entries held or in flight after this cycle's pop; a new read must find a slot next cycle.
  assign occ_c      = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop_c);
  assign rd_issue_c = rd_avail_c && (occ_c < 2'd2);
  assign rd_end_c   = (rd_addr_q == '1);

  // Per-bank lifecycle: fill, hand to read side, drain, release.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_d[b] = bank_q[b];
      case (bank_q[b])
        B_EMPTY:    if (wr_acc_c && (wr_bank_q == 1'(b))) bank_d[b] = B_FILLING;
        B_FILLING:  if (s1_vld_q && s1_end_q && (s1_bank_q == 1'(b))) bank_d[b] = B_FULL;
        B_FULL:     if (rd_issue_c && (rd_bank_q == 1'(b))) bank_d[b] = B_DRAINING;
        B_DRAINING: if (pop_c && out_last_q && (drain_bank_q == 1'(b))) bank_d[b] = B_EMPTY;
        default:    bank_d[b] = B_EMPTY;
      endcase
    end
    ready_d = (bank_d[wr_bank_d] == B_EMPTY) || (bank_d[wr_bank_d] == B_FILLING);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bank_q[0]    <= B_EMPTY;
      bank_q[1]    <= B_EMPTY;
      ready_q      <= 1'b0;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      bank_q[0]    <= bank_d[0];
      bank_q[1]    <= bank_d[1];
      ready_q      <= ready_d;
      wr_bank_q    <= wr_bank_d;
      if (wr_acc_c) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (i_data_last != wr_end_c) err_q <= 1'b1;
      end
    end
  end

  // Squares registered one cycle after accept; the sum is written the next cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_end_q  <= 1'b0;
      s1_bank_q <= 1'b0;
      s1_addr_q <= '0;
      s1_pre_q  <= '0;
      s1_pim_q  <= '0;
    end else begin
      s1_vld_q <= wr_acc_c;
      if (wr_acc_c) begin
        s1_end_q  <= wr_end_c;
        s1_bank_q <= wr_bank_q;
        s1_addr_q <= BITREV_IN ? bitrev(wr_cnt_q) : wr_cnt_q;
        s1_pre_q  <= pre_c;
        s1_pim_q  <= pim_c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (s1_vld_q) mem[{s1_bank_q, s1_addr_q}] <= pwr_c;
    if (rd_issue_c) ram_data_q <= mem[{rd_bank_q, rd_addr_q}];
  end

  // Read issue pointer moves to the other bank as soon as its last address is issued,
  // so the next frame follows without a bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_bank_q    <= 1'b0;
      rd_addr_q    <= '0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      drain_bank_q <= 1'b0;
    end else begin
      ram_vld_q <= rd_issue_c;
      if (rd_issue_c) begin
        ram_last_q <= rd_end_c;
        rd_addr_q  <= rd_addr_q + 1'b1;
        if (rd_end_c) rd_bank_q <= ~rd_bank_q;
      end
      if (pop_c && out_last_q) drain_bank_q <= ~drain_bank_q;
    end
  end

  // Output register with a one-entry skid absorbing the RAM read latency under backpressure.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_last_q <= 1'b0;
      skid_data_q <= '0;
    end else if (!out_vld_q || pop_c) begin
      if (skid_vld_q) begin
        out_vld_q   <= 1'b1;
        out_last_q  <= skid_last_q;
        out_data_q  <= skid_data_q;
        skid_vld_q  <= ram_vld_q;
        skid_last_q <= ram_last_q;
        skid_data_q <= ram_data_q;
      end else if (ram_vld_q) begin
        out_vld_q  <= 1'b1;
        out_last_q <= ram_last_q;
        out_data_q <= ram_data_q;
      end else begin
        out_vld_q <= 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_vld_q  <= 1'b1;
      skid_last_q <= ram_last_q;
      skid_data_q <= ram_data_q;
    end
  end

  assign o_data_ready = ready_q;
  assign o_data       = out_data_q;
  assign o_data_valid = out_vld_q;
  assign o_data_last  = out_last_q;
  assign o_frame_err  = err_q;

endmodule

// File: tb/tb_fft_bin_reorder.sv
// Directed bench for fft_bin_reorder: reorder, arithmetic extremes, backpressure,
// two-bank overflow protection, framing error and mid-frame reset.
module tb_fft_bin_reorder;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [31:0] i_data;
  logic        i_data_valid;
  logic        i_data_last;
  logic        o_data_ready;
  logic [31:0] o_data;
  logic        o_data_valid;
  logic        o_data_last;
  logic        i_data_ready;
  logic        o_frame_err;

  fft_bin_reorder #(.N_LOG2(8), .SHIFT(1), .BITREV_IN(1'b1)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .i_data_last  (i_data_last),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_data_last  (o_data_last),
    .i_data_ready (i_data_ready),
    .o_frame_err  (o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  int          total = 0;
  int          bad = 0;
  logic [32:0] in_q[$];
  logic [32:0] exp_q[$];
  logic [32:0] out_q[$];
  int          in_idx = 0;
  int          cyc = 0;
  int          hs_cyc = -1;
  int          vld_cyc = -1;
  bit          bp_mode = 1'b0;
  logic        rdy_lvl = 1'b1;
  logic [31:0] frm [256];

  function automatic logic [7:0] br8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction

  function automatic logic [31:0] pwr(input logic [31:0] d);
    longint re, im;
    re = longint'($signed(d[15:0]));
    im = longint'($signed(d[31:16]));
    return 32'((re * re + im * im) >> 1);
  endfunction

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (in_idx < in_q.size()) begin
      i_data_valid = 1'b1;
      {i_data_last, i_data} = in_q[in_idx];
    end else begin
      i_data_valid = 1'b0;
      i_data_last  = 1'b0;
      i_data       = '0;
    end
    i_data_ready = bp_mode ? 1'($urandom_range(0, 1)) : rdy_lvl;
  endtask

  task automatic tick();
    logic        in_hs, out_hs, stall;
    logic [32:0] held;
    in_hs  = i_data_valid && o_data_ready;
    out_hs = o_data_valid && i_data_ready;
    stall  = o_data_valid && !i_data_ready;
    held   = {o_data_last, o_data};
    if (in_hs && ((in_idx % 256) == 255)) hs_cyc = cyc;
    @(posedge i_clk);
    #1;
    cyc++;
    if (out_hs) out_q.push_back(held);
    if (stall) chk("stall_hold", {o_data_last, o_data}, held);
    if (in_hs) in_idx++;
    if (o_data_valid && (vld_cyc < 0)) vld_cyc = cyc;
    drive();
  endtask

  task automatic push_frame(input int last_pos);
    for (int j = 0; j < 256; j++) in_q.push_back({1'(j == last_pos), frm[j]});
    for (int k = 0; k < 256; k++) exp_q.push_back({1'(k == 255), pwr(frm[br8(8'(k))])});
  endtask

  task automatic clear_q();
    in_q.delete();
    exp_q.delete();
    out_q.delete();
    in_idx = 0;
  endtask

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while (((in_idx < in_q.size()) || (out_q.size() < exp_q.size())) && (n < budget)) begin
      tick();
      n++;
    end
    chk({tag, "_in_budget"}, 33'(n < budget), 33'd1);
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_count"}, 33'(out_q.size()), 33'(exp_q.size()));
    for (int i = 0; (i < exp_q.size()) && (i < out_q.size()); i++)
      chk($sformatf("%s_bin%0d", tag, i), out_q[i], exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    i_rst_n = 1'b0;
    drive();
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", 33'(o_data_valid), 33'd0);
    chk("rst_last",  33'(o_data_last),  33'd0);
    chk("rst_err",   33'(o_frame_err),  33'd0);
    chk("rst_data",  33'(o_data),       33'd0);
    chk("rst_ready", 33'(o_data_ready), 33'd0);
    i_rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 33'(o_data_ready), 33'd1);

    // single frame: re = bitrev(j) -> bin k = k*k >> 1
    for (int j = 0; j < 256; j++) frm[j] = {24'h0, br8(8'(j))};
    hs_cyc = -1;
    vld_cyc = -1;
    push_frame(255);
    drive();
    run_done("frameA", 1000);
    chk("latency", 33'(vld_cyc - hs_cyc), 33'd4);
    chk("frameA_bin3",   out_q[3],   {1'b0, 32'd4});
    chk("frameA_bin255", out_q[255], {1'b1, 32'd32512});
    chk("frameA_bin254_notlast", out_q[254], {1'b0, 32'd32258});
    cmp_frames("frameA");
    clear_q();
    repeat (4) tick();

    // arithmetic extremes
    for (int j = 0; j < 256; j++) frm[j] = 32'h0;
    frm[0] = 32'h8000_8000;
    frm[1] = 32'h0000_7FFF;
    frm[2] = 32'hFFFF_0001;
    push_frame(255);
    drive();
    run_done("ext", 1000);
    chk("ext_min_min",  out_q[0],   {1'b0, 32'h4000_0000});
    chk("ext_max_zero", out_q[128], {1'b0, 32'h1FFF_8000});
    chk("ext_one_m1",   out_q[64],  {1'b0, 32'h0000_0001});
    chk("ext_zero",     out_q[1],   {1'b0, 32'h0000_0000});
    cmp_frames("ext");
    clear_q();
    repeat (4) tick();

    // random 50% backpressure over four frames
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < 256; j++) frm[j] = $urandom();
      push_frame(255);
    end
    bp_mode = 1'b1;
    drive();
    run_done("bp", 6000);
    cmp_frames("bp");
    bp_mode = 1'b0;
    rdy_lvl = 1'b1;
    clear_q();
    drive();
    repeat (4) tick();

    // overflow protection: downstream blocked, three frames offered
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 256; j++) frm[j] = $urandom();
      push_frame(255);
    end
    rdy_lvl = 1'b0;
    drive();
    repeat (700) tick();
    chk("ovf_accepted", 33'(in_idx), 33'd512);
    chk("ovf_ready_low", 33'(o_data_ready), 33'd0);
    chk("ovf_no_output", 33'(out_q.size()), 33'd0);
    rdy_lvl = 1'b1;
    drive();
    run_done("ovf", 3000);
    cmp_frames("ovf");
    clear_q();
    repeat (4) tick();

    // framing error: last on sample 100
    for (int j = 0; j < 256; j++) frm[j] = $urandom();
    push_frame(100);
    drive();
    n = 0;
    while ((in_idx < 100) && (n < 500)) begin tick(); n++; end
    chk("frm_err_before", 33'(o_frame_err), 33'd0);
    tick();
    chk("frm_accepted_100", 33'(in_idx), 33'd101);
    chk("frm_err_set", 33'(o_frame_err), 33'd1);
    run_done("frm", 1000);
    chk("frm_err_sticky", 33'(o_frame_err), 33'd1);
    cmp_frames("frm");
    clear_q();
    repeat (4) tick();

    // reset at sample 130 of the second frame
    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 256; j++) frm[j] = $urandom();
      push_frame(255);
    end
    drive();
    n = 0;
    while ((in_idx < 386) && (n < 2000)) begin tick(); n++; end
    chk("mrst_reached", 33'(in_idx), 33'd386);
    i_rst_n = 1'b0;
    clear_q();
    drive();
    #1;
    chk("mrst_valid_low", 33'(o_data_valid), 33'd0);
    chk("mrst_ready_low", 33'(o_data_ready), 33'd0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    tick();
    chk("mrst_ready_high", 33'(o_data_ready), 33'd1);
    chk("mrst_err_clear", 33'(o_frame_err), 33'd0);
    repeat (300) tick();
    chk("mrst_no_output", 33'(out_q.size()), 33'd0);
    for (int j = 0; j < 256; j++) frm[j] = {16'(j), 8'h00, br8(8'(j)) ^ 8'h55};
    push_frame(255);
    drive();
    run_done("fresh", 1000);
    cmp_frames("fresh");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
